ram_block_master: RTL and testbench
===================================

Name: ram_block_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave (fixed 1-cycle read latency, no waitrequest) from a simple command interface.
- Executes three block operations word by word: FILL, COPY and CHECK.
- Sits between a control source (Nios PIO or test FSM) and the RAM slave port.
- Replaces software init/scrub loops.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width; byteenable is DATA_W/8 bits.
- DEPTH, 5120, number of RAM words; addresses wrap modulo DEPTH.
- LEN_W, 14, width of the length field; must satisfy 2^LEN_W > DEPTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_start  in  1  one-cycle start strobe; ignored while busy=1
- cmd_op  in  2  operation: 0=FILL, 1=COPY, 2=CHECK, 3=reserved (sets err)
- cmd_src  in  ADDR_W  source start address (COPY and CHECK)
- cmd_dst  in  ADDR_W  destination start address (FILL and COPY)
- cmd_len  in  LEN_W  number of words
- cmd_pattern  in  DATA_W  fill value (FILL) or expected value (CHECK)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky: bad op or cmd_len>DEPTH; cleared by the next accepted start
- mismatch_cnt  out  LEN_W  CHECK mismatch count
- address  out  ADDR_W  to slave
- byteenable  out  DATA_W/8  to slave; all ones
- chipselect  out  1  to slave
- write  out  1  to slave
- writedata  out  DATA_W  to slave
- clken  out  1  to slave; constant 1
- readdata  in  DATA_W  from slave; valid the cycle after a read is issued

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, mismatch_cnt=0.
  - chipselect=0, write=0, address=0, writedata=0.
  - byteenable all ones; clken=1.
- Start acceptance: cmd_start is accepted only in IDLE. All cmd_* fields are latched on the accepted cycle. err and mismatch_cnt clear on acceptance.
- Immediate completion (no bus access, done pulses the next cycle):
  - cmd_len=0.
  - cmd_len>DEPTH, or cmd_op=3: err=1 as well.
- States: IDLE, FILL_WR, RD, CAP, WR, CHK, DONE.
- FILL:
  - FILL_WR holds chipselect=1, write=1, writedata=pattern, address=dst pointer.
  - One word per cycle; cmd_len cycles in total.
- COPY, 3 cycles per word:
  - RD: chipselect=1, write=0, address=src pointer.
  - CAP: bus idle; readdata is registered into the data register.
  - WR: chipselect=1, write=1, address=dst pointer, writedata=data register.
  - Sequence RD→CAP→WR, then back to RD until the count is exhausted.
- CHECK, 2 cycles per word:
  - RD as for COPY.
  - CHK: compare readdata with pattern; mismatch_cnt increments on inequality.
  - Sequence RD→CHK.
- Pointers:
  - Each pointer increments after its own access.
  - DEPTH-1 wraps to 0; addresses never exceed DEPTH-1.
  - Overlapping COPY regions are processed in ascending order with no hazard protection (each word is read, then written).
- DONE state:
  - Bus idle.
  - done=1 for exactly one cycle, busy=0 in the same cycle; next state is IDLE.
- busy is 1 from the cycle after acceptance until the DONE cycle.
- chipselect is 0 in every state other than FILL_WR, RD and WR.
- Reset mid-operation: at the next edge the block returns to IDLE with all outputs at reset values; no partial-word write completes after that edge.
- cmd_start in the DONE cycle is ignored; it is accepted only in IDLE.
- mismatch_cnt saturates at 2^LEN_W-1.

Optional Feature:
- Macro: RAM_BLOCK_MASTER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[DATA_W-1:0], cleared on an accepted start.
  - Accumulates a modulo-2^DATA_W sum of every word written (FILL, COPY) or read (CHECK).
  - Valid when done pulses; held until the next start.
- Undefined: port and logic absent.

Decomposition:
- Package ram_block_master_pkg holds:
  - op enum: OP_FILL, OP_COPY, OP_CHECK, OP_RSVD.
  - state enum.
  - default ADDR_W, DATA_W, DEPTH, LEN_W constants.
- One sub-module: ram_addr_wrap_ctr, a loadable pointer with increment and wrap at DEPTH-1. Instantiated twice (src, dst).

Test Plan:
- Fill: FILL dst=0x100 len=4 pattern=0xA5A5_0001.
  - 4 consecutive write cycles at 0x100..0x103.
  - done pulses 1 cycle after the last write.
  - Readback equals the pattern.
- Copy: preload 0x000..0x002 with 1,2,3; COPY src=0 dst=0x200 len=3.
  - 0x200..0x202 hold 1,2,3.
  - 9 busy cycles plus the DONE cycle.
- Check: CHECK src=0x100 len=4 pattern=0xA5A5_0001 after corrupting 0x102 → mismatch_cnt=1, err=0.
- Wrap: FILL dst=5118 len=4 → writes to 5118, 5119, 0, 1; address never reaches 5120.
- Errors:
  - len=0 → done the next cycle, no chipselect.
  - len=5121 → err=1, done, no chipselect.
  - op=3 → err=1.
  - The next valid start clears err.
- Reset mid-run: assert reset during the WR state of a COPY.
  - Next cycle chipselect=0, busy=0.
  - A new FILL is accepted immediately afterwards.
  - With the macro defined, checksum of FILL len=4 pattern=1 equals 4.

Source files
------------

// File: rtl/ram_block_master_pkg.sv
// Shared types and default sizing for the RAM block master (FILL / COPY / CHECK engine).
// Default geometry matches the 5120-word on-chip RAM.
package ram_block_master_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 5120;
  localparam int LEN_W_DEF  = 14;

  typedef enum logic [1:0] {
    OP_FILL  = 2'd0,
    OP_COPY  = 2'd1,
    OP_CHECK = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL_WR = 3'd1,
    S_RD      = 3'd2,
    S_CAP     = 3'd3,
    S_WR      = 3'd4,
    S_CHK     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/ram_block_master_if.sv
// Avalon-MM bus between the block master and a single-port RAM slave.
// Slave has fixed 1-cycle read latency and no waitrequest.
interface ram_block_master_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/ram_addr_wrap_ctr.sv
// Loadable word pointer that steps by one and wraps DEPTH-1 -> 0.
// Latency: new value visible the cycle after load/inc; no backpressure.
module ram_addr_wrap_ctr #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] load_wrapped;

  // Out-of-range start addresses fold back into the RAM once.
  always_comb begin
    load_wrapped = load_val;
    if (int'(load_val) >= DEPTH) begin
      load_wrapped = load_val - ADDR_W'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_wrapped;
    end else if (inc) begin
      ptr <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ram_block_master.sv
// Avalon-MM block engine: FILL (1 cyc/word), COPY (3 cyc/word), CHECK (2 cyc/word); done 1 cycle after last word.
// No backpressure: slave never stalls; cmd_start is ignored unless idle. Optional RAM_BLOCK_MASTER_CHECKSUM_EN adds checksum.
module ram_block_master
  import ram_block_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  mismatch_cnt,
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  ram_block_master_if.master avm
);

  state_t            state, state_nxt;
  op_t               op_q;
  logic [DATA_W-1:0] pattern_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  remain;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              accept, bad_cmd, last_word;
  logic              src_inc, dst_inc;
  logic              cs, wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdat;

  assign accept    = (state == S_IDLE) && cmd_start;
  assign bad_cmd   = (op_t'(cmd_op) == OP_RSVD) || (cmd_len > LEN_W'(DEPTH));
  assign last_word = (remain == LEN_W'(1));

  ram_addr_wrap_ctr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_src_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (cmd_src),
    .inc      (src_inc),
    .ptr      (src_ptr)
  );

  ram_addr_wrap_ctr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dst_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (cmd_dst),
    .inc      (dst_inc),
    .ptr      (dst_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_cmd || (cmd_len == '0)) begin
            state_nxt = S_DONE;
          end else if (op_t'(cmd_op) == OP_FILL) begin
            state_nxt = S_FILL_WR;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_FILL_WR: state_nxt = last_word ? S_DONE : S_FILL_WR;
      S_RD:      state_nxt = (op_q == OP_COPY) ? S_CAP : S_CHK;
      S_CAP:     state_nxt = S_WR;
      S_WR:      state_nxt = last_word ? S_DONE : S_RD;
      S_CHK:     state_nxt = last_word ? S_DONE : S_RD;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdat    = '0;
    busy    = 1'b0;
    done    = 1'b0;
    src_inc = 1'b0;
    dst_inc = 1'b0;
    unique case (state)
      S_FILL_WR: begin
        cs      = 1'b1;
        wr      = 1'b1;
        addr    = dst_ptr;
        wdat    = pattern_q;
        busy    = 1'b1;
        dst_inc = 1'b1;
      end
      S_RD: begin
        cs      = 1'b1;
        addr    = src_ptr;
        busy    = 1'b1;
        src_inc = 1'b1;
      end
      S_WR: begin
        cs      = 1'b1;
        wr      = 1'b1;
        addr    = dst_ptr;
        wdat    = data_q;
        busy    = 1'b1;
        dst_inc = 1'b1;
      end
      S_CAP, S_CHK: busy = 1'b1;
      S_DONE:       done = 1'b1;
      default: ;
    endcase
  end

  assign avm.chipselect = cs;
  assign avm.write      = wr;
  assign avm.address    = addr;
  assign avm.writedata  = wdat;
  assign avm.byteenable = '1;
  assign avm.clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= OP_FILL;
      pattern_q    <= '0;
      data_q       <= '0;
      remain       <= '0;
      err          <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (accept) begin
        op_q         <= op_t'(cmd_op);
        pattern_q    <= cmd_pattern;
        remain       <= cmd_len;
        err          <= bad_cmd;
        mismatch_cnt <= '0;
      end
      if (state == S_CAP) begin
        data_q <= avm.readdata;
      end
      // One word retires in each write or compare cycle.
      if ((state == S_FILL_WR) || (state == S_WR) || (state == S_CHK)) begin
        remain <= remain - LEN_W'(1);
      end
      if ((state == S_CHK) && (avm.readdata != pattern_q) && (mismatch_cnt != '1)) begin
        mismatch_cnt <= mismatch_cnt + LEN_W'(1);
      end
    end
  end

`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (wr) begin
      checksum <= checksum + wdat;
    end else if (state == S_CHK) begin
      checksum <= checksum + avm.readdata;
    end
  end
`endif

endmodule

// File: tb/tb_ram_block_master.sv
// Bench for ram_block_master: RAM slave model, per-command expected bus trace, literal spot checks.
module tb_ram_block_master;
  import ram_block_master_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int D  = 5120;
  localparam int LW = 14;

  logic          clk;
  logic          reset;
  logic          cmd_start;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_pattern;
  logic          busy, done, err;
  logic [LW-1:0] mismatch_cnt;
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_block_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_block_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .LEN_W(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_start    (cmd_start),
    .cmd_op       (cmd_op),
    .cmd_src      (cmd_src),
    .cmd_dst      (cmd_dst),
    .cmd_len      (cmd_len),
    .cmd_pattern  (cmd_pattern),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt),
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .avm          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM slave with a backdoor write port for preloading and corruption.
  logic [DW-1:0] ram [D];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (bus.chipselect) begin
      if (bus.write) begin
        if (int'(bus.address) < D) ram[bus.address] <= bus.writedata;
      end else begin
        bus.readdata <= ram[bus.address];
      end
    end
  end

  typedef struct {
    logic          cs, wr, busy, done, err, fin, first;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [LW-1:0] mm;
    logic [DW-1:0] sum;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  logic [DW-1:0] ref_mem [D];
  logic          model_err;
  logic [LW-1:0] model_mm;
  logic [DW-1:0] model_sum;
  int            checks = 0;
  int            errors = 0;
  int            busy_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.first) busy_cycles = 0;
      if (busy === 1'b1) busy_cycles++;
      chk("chipselect", 64'(bus.chipselect), 64'(cur.cs));
      chk("write", 64'(bus.write), 64'(cur.wr));
      chk("busy", 64'(busy), 64'(cur.busy));
      chk("done", 64'(done), 64'(cur.done));
      chk("err", 64'(err), 64'(cur.err));
      if (cur.cs) begin
        chk("address", 64'(bus.address), 64'(cur.addr));
        chk("addr_range", 64'(int'(bus.address) < D), 64'(1));
      end
      if (cur.wr) chk("writedata", 64'(bus.writedata), 64'(cur.wd));
      if (cur.fin) begin
        chk("mismatch_cnt", 64'(mismatch_cnt), 64'(cur.mm));
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(cur.sum));
`endif
      end
    end
  end

  task automatic push(input logic cs, input logic wr, input int addr, input logic [DW-1:0] wd,
                      input logic bsy, input logic dn, input logic fin, input logic first);
    exp_t e;
    e.cs = cs; e.wr = wr; e.addr = AW'(addr); e.wd = wd;
    e.busy = bsy; e.done = dn; e.err = model_err; e.fin = fin; e.first = first;
    e.mm = model_mm; e.sum = model_sum;
    exp_q.push_back(e);
  endtask

  // Expected behaviour of one command, derived word by word from the operation rules.
  task automatic run_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                         input logic [DW-1:0] pat);
    int s, d, g;
    logic [DW-1:0] v;
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_op = op; cmd_src = AW'(src); cmd_dst = AW'(dst);
    cmd_len = LW'(len); cmd_pattern = pat;
    push(0, 0, 0, '0, 0, 0, 0, 1);
    model_err = (op == 2'd3) || (len > D);
    model_mm  = '0;
    model_sum = '0;
    if (!model_err && len != 0) begin
      for (int i = 0; i < len; i++) begin
        s = (src + i) % D;
        d = (dst + i) % D;
        if (op == 2'd0) begin
          ref_mem[d] = pat;
          model_sum += pat;
          push(1, 1, d, pat, 1, 0, 0, 0);
        end else if (op == 2'd1) begin
          v = ref_mem[s];
          push(1, 0, s, '0, 1, 0, 0, 0);
          push(0, 0, 0, '0, 1, 0, 0, 0);
          push(1, 1, d, v, 1, 0, 0, 0);
          ref_mem[d] = v;
          model_sum += v;
        end else begin
          push(1, 0, s, '0, 1, 0, 0, 0);
          push(0, 0, 0, '0, 1, 0, 0, 0);
          if (ref_mem[s] != pat && model_mm != '1) model_mm++;
          model_sum += ref_mem[s];
        end
      end
    end
    push(0, 0, 0, '0, 0, 1, 1, 0);
    @(posedge clk); #1;
    cmd_start = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() > 0) begin
      chk("timeout_pending", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    #1;
  endtask

  task automatic bd_write(input int a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = AW'(a); bd_data = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  initial begin
    int g;
    reset = 1'b1; cmd_start = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_pattern = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    model_err = 1'b0; model_mm = '0; model_sum = '0;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_mismatch", 64'(mismatch_cnt), 64'(0));
    chk("rst_cs", 64'(bus.chipselect), 64'(0));
    chk("rst_write", 64'(bus.write), 64'(0));
    chk("rst_address", 64'(bus.address), 64'(0));
    chk("rst_writedata", 64'(bus.writedata), 64'(0));
    chk("rst_byteenable", 64'(bus.byteenable), 64'h0f);
    chk("rst_clken", 64'(bus.clken), 64'(1));
    reset = 1'b0;

    // FILL 0x100..0x103
    run_cmd(2'd0, 'h100, 'h100, 4, 32'hA5A5_0001);
    for (int i = 0; i < 4; i++) chk("fill_readback", 64'(ram['h100 + i]), 64'hA5A5_0001);

    // COPY 0..2 -> 0x200
    bd_write(0, 32'd1); bd_write(1, 32'd2); bd_write(2, 32'd3);
    run_cmd(2'd1, 0, 'h200, 3, '0);
    chk("copy_w0", 64'(ram['h200]), 64'd1);
    chk("copy_w1", 64'(ram['h201]), 64'd2);
    chk("copy_w2", 64'(ram['h202]), 64'd3);
    chk("copy_busy_cycles", 64'(busy_cycles), 64'd9);

    // CHECK with one corrupted word
    bd_write('h102, 32'h0000_0000);
    run_cmd(2'd2, 'h100, 0, 4, 32'hA5A5_0001);
    chk("check_mismatch", 64'(mismatch_cnt), 64'd1);
    chk("check_err", 64'(err), 64'd0);

    // FILL across the top of the RAM
    run_cmd(2'd0, 0, 5118, 4, 32'h5A5A_0002);
    chk("wrap_5118", 64'(ram[5118]), 64'h5A5A_0002);
    chk("wrap_5119", 64'(ram[5119]), 64'h5A5A_0002);
    chk("wrap_0", 64'(ram[0]), 64'h5A5A_0002);
    chk("wrap_1", 64'(ram[1]), 64'h5A5A_0002);

    // Immediate completions and error clearing
    run_cmd(2'd0, 0, 'h600, 0, 32'h1234);
    chk("len0_err", 64'(err), 64'd0);
    run_cmd(2'd0, 0, 'h600, 5121, 32'h1234);
    chk("len_big_err", 64'(err), 64'd1);
    run_cmd(2'd3, 0, 'h600, 4, 32'h1234);
    chk("op3_err", 64'(err), 64'd1);
    run_cmd(2'd0, 0, 'h500, 2, 32'hCAFE_F00D);
    chk("err_cleared", 64'(err), 64'd0);

    // Reset while a COPY is in its write cycle
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_op = 2'd1; cmd_src = '0; cmd_dst = AW'('h300); cmd_len = LW'(3);
    @(posedge clk); #1;
    cmd_start = 1'b0;
    g = 0;
    while (bus.write !== 1'b1 && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    chk("reach_wr_state", 64'(g < 10), 64'd1);
    ref_mem['h300] = ref_mem[0];
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_cs", 64'(bus.chipselect), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_write", 64'(bus.write), 64'd0);
    model_err = 1'b0;
    run_cmd(2'd0, 0, 'h400, 4, 32'd1);
    chk("post_rst_fill", 64'(ram['h403]), 64'd1);
`ifdef RAM_BLOCK_MASTER_CHECKSUM_EN
    chk("checksum_fill4", 64'(checksum), 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
